// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
package mips_ctrl_pkg;

   localparam int unsigned OP_W     = 6;
   localparam int unsigned FUNCT_W  = 6;
   localparam int unsigned ALUOP_W  = 2;
   localparam int unsigned ALUCTL_W = 3;
   localparam int unsigned STATE_W  = 4;

   typedef enum logic [STATE_W-1:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      EXECUTE = 4'd6,
      ALUWB   = 4'd7,
      BRANCH  = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JUMP    = 4'd11
   } state_e;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OP_W-1:0] OP_J     = 6'b000010;

   localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
   localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
   localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
   localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
   localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

   localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
   localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
   localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [ALUCTL_W-1:0] ALU_ADD = 3'b010;
   localparam logic [ALUCTL_W-1:0] ALU_SUB = 3'b110;
   localparam logic [ALUCTL_W-1:0] ALU_AND = 3'b000;
   localparam logic [ALUCTL_W-1:0] ALU_OR  = 3'b001;
   localparam logic [ALUCTL_W-1:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/alu_decoder.sv
// Translates ALUOp plus the R-type funct field into the ALU's 3-bit F code.
module alu_decoder
   import mips_ctrl_pkg::*;
(
   input  logic [ALUOP_W-1:0]  alu_op_i,
   input  logic [FUNCT_W-1:0]  funct_i,
   output logic [ALUCTL_W-1:0] alu_control_o
);

   always_comb begin
      alu_control_o = ALU_ADD;
      case (alu_op_i)
         ALUOP_ADD: alu_control_o = ALU_ADD;
         ALUOP_SUB: alu_control_o = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct_i)
               FN_ADD:  alu_control_o = ALU_ADD;
               FN_SUB:  alu_control_o = ALU_SUB;
               FN_AND:  alu_control_o = ALU_AND;
               FN_OR:   alu_control_o = ALU_OR;
               FN_SLT:  alu_control_o = ALU_SLT;
               default: alu_control_o = ALU_ADD;
            endcase
         end
         default: alu_control_o = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore control FSM for the multicycle MIPS datapath.
// Optional BNE_EN adds bne via the BRANCH state with an inverted-Zero flag.
module mips_multicycle_ctrl
   import mips_ctrl_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic [OP_W-1:0]     Op,
   input  logic [FUNCT_W-1:0]  Funct,
   input  logic                Zero,
   output logic                IorD,
   output logic                MemWrite,
   output logic                IRWrite,
   output logic                RegDst,
   output logic                MemtoReg,
   output logic                RegWrite,
   output logic                ALUSrcA,
   output logic [1:0]          ALUSrcB,
   output logic [1:0]          PCSrc,
   output logic                PCEn,
   output logic [ALUCTL_W-1:0] ALUControl,
   output logic [STATE_W-1:0]  State
);

   state_e               state_q, state_d, state_eff;
   logic [ALUOP_W-1:0]   alu_op;
   logic                 pc_write;
   logic                 branch;
   logic                 is_bne;

   always_ff @(posedge clk) begin
      if (reset) state_q <= FETCH;
      else       state_q <= state_d;
   end

`ifdef BNE_EN
   logic is_bne_q, is_bne_d;

   // Branch polarity is latched in DECODE so BRANCH need not re-decode Op.
   always_comb begin
      is_bne_d = is_bne_q;
      if (state_q == DECODE) is_bne_d = (Op == OP_BNE);
   end

   always_ff @(posedge clk) begin
      if (reset) is_bne_q <= 1'b0;
      else       is_bne_q <= is_bne_d;
   end

   assign is_bne = is_bne_q;
`else
   assign is_bne = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH: state_d = DECODE;
         DECODE: begin
            case (Op)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_RTYPE:     state_d = EXECUTE;
               OP_BEQ:       state_d = BRANCH;
`ifdef BNE_EN
               OP_BNE:       state_d = BRANCH;
`endif
               OP_ADDI:      state_d = ADDIEX;
               OP_J:         state_d = JUMP;
               default:      state_d = FETCH;
            endcase
         end
         MEMADR: begin
            if (Op == OP_LW)      state_d = MEMRD;
            else if (Op == OP_SW) state_d = MEMWR;
            else                  state_d = FETCH;
         end
         MEMRD:   state_d = MEMWB;
         MEMWB:   state_d = FETCH;
         MEMWR:   state_d = FETCH;
         EXECUTE: state_d = ALUWB;
         ALUWB:   state_d = FETCH;
         BRANCH:  state_d = FETCH;
         ADDIEX:  state_d = ADDIWB;
         ADDIWB:  state_d = FETCH;
         JUMP:    state_d = FETCH;
         default: state_d = FETCH;
      endcase
   end

   // While reset is high the outputs present FETCH with every write enable held low.
   always_comb begin
      state_eff = reset ? FETCH : state_q;
      IorD      = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      RegDst    = 1'b0;
      MemtoReg  = 1'b0;
      RegWrite  = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 2'b00;
      PCSrc     = 2'b00;
      alu_op    = ALUOP_ADD;
      pc_write  = 1'b0;
      branch    = 1'b0;
      case (state_eff)
         FETCH: begin
            IRWrite  = 1'b1;
            ALUSrcB  = 2'b01;
            pc_write = 1'b1;
         end
         DECODE:  ALUSrcB = 2'b11;
         MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         MEMRD:   IorD = 1'b1;
         MEMWB: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
         end
         MEMWR: begin
            IorD     = 1'b1;
            MemWrite = 1'b1;
         end
         EXECUTE: begin
            ALUSrcA = 1'b1;
            alu_op  = ALUOP_FUNCT;
         end
         ALUWB: begin
            RegDst   = 1'b1;
            RegWrite = 1'b1;
         end
         BRANCH: begin
            ALUSrcA = 1'b1;
            alu_op  = ALUOP_SUB;
            PCSrc   = 2'b01;
            branch  = 1'b1;
         end
         ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         ADDIWB:  RegWrite = 1'b1;
         JUMP: begin
            PCSrc    = 2'b10;
            pc_write = 1'b1;
         end
         default: ;
      endcase
      PCEn = pc_write | (branch & (Zero ^ is_bne));
      if (reset) begin
         IRWrite  = 1'b0;
         MemWrite = 1'b0;
         RegWrite = 1'b0;
         PCEn     = 1'b0;
      end
      State = STATE_W'(state_eff);
   end

   alu_decoder u_alu_decoder (
      .alu_op_i      (alu_op),
      .funct_i       (Funct),
      .alu_control_o (ALUControl)
   );

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: directed table, reset aborts, randomized instruction stream.
module tb_mips_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] Op;
   logic [5:0] Funct;
   logic       Zero;
   logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn;
   logic [1:0] ALUSrcB, PCSrc;
   logic [2:0] ALUControl;
   logic [3:0] State;

   int n_vec = 0;
   int n_err = 0;

   mips_multicycle_ctrl dut (
      .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
      .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
      .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .PCSrc(PCSrc), .PCEn(PCEn), .ALUControl(ALUControl), .State(State)
   );

   always #5 clk = ~clk;

   logic [18:0] dut_vec;
   assign dut_vec = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                     ALUSrcB, PCSrc, PCEn, ALUControl, State};

   localparam logic [5:0] T_R = 6'b000000, T_LW = 6'b100011, T_SW = 6'b101011,
                          T_BEQ = 6'b000100, T_BNE = 6'b000101, T_ADDI = 6'b001000,
                          T_J = 6'b000010;

`ifdef BNE_EN
   localparam bit HAS_BNE = 1'b1;
`else
   localparam bit HAS_BNE = 1'b0;
`endif

   function automatic logic [2:0] funct_alu(input logic [5:0] fn);
      case (fn)
         6'b100000: return 3'b010;
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   // Expected output bundle for a state number, taken from the per-state output table.
   function automatic logic [18:0] model(input int st, input logic [5:0] op, input logic [5:0] fn,
                                         input logic z, input logic rst);
      logic iord, memw, irw, rdst, m2r, rw, srca, pcen;
      logic [1:0] srcb, pcsrc;
      logic [2:0] alu;
      iord = 0; memw = 0; irw = 0; rdst = 0; m2r = 0; rw = 0; srca = 0; pcen = 0;
      srcb = 2'b00; pcsrc = 2'b00; alu = 3'b010;
      if (rst) begin
         srcb = 2'b01;
         return {iord, memw, irw, rdst, m2r, rw, srca, srcb, pcsrc, pcen, alu, 4'd0};
      end
      case (st)
         0:  begin irw = 1; srcb = 2'b01; pcen = 1; end
         1:  srcb = 2'b11;
         2:  begin srca = 1; srcb = 2'b10; end
         3:  iord = 1;
         4:  begin rw = 1; m2r = 1; end
         5:  begin iord = 1; memw = 1; end
         6:  begin srca = 1; alu = funct_alu(fn); end
         7:  begin rdst = 1; rw = 1; end
         8:  begin srca = 1; alu = 3'b110; pcsrc = 2'b01;
                   pcen = z ^ (HAS_BNE && op == T_BNE); end
         9:  begin srca = 1; srcb = 2'b10; end
         10: rw = 1;
         11: begin pcsrc = 2'b10; pcen = 1; end
         default: ;
      endcase
      return {iord, memw, irw, rdst, m2r, rw, srca, srcb, pcsrc, pcen, alu, 4'(st)};
   endfunction

   // {length, state visited at step 5..0} for each instruction class.
   function automatic logic [27:0] seq_of(input logic [5:0] op);
      case (op)
         T_LW:   return 28'h5_043210;
         T_SW:   return 28'h4_005210;
         T_R:    return 28'h4_007610;
         T_BEQ:  return 28'h3_000810;
         T_ADDI: return 28'h4_00A910;
         T_J:    return 28'h3_000B10;
         T_BNE:  return HAS_BNE ? 28'h3_000810 : 28'h2_000010;
         default: return 28'h2_000010;
      endcase
   endfunction

   task automatic check(input string name, input logic [18:0] exp);
      n_vec++;
      if (dut_vec !== exp) begin
         n_err++;
         $display("FAIL %s: got %b required %b (t=%0t)", name, dut_vec, exp, $time);
      end
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d required %0d", name, got, exp);
      end
   endtask

   // Call just after the edge that entered FETCH; returns cycles until FETCH re-entry.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zmode,
                            output int cycles);
      logic [27:0] sq;
      int          len;
      int          k;
      logic        z;
      logic [3:0]  st;
      sq = seq_of(op);
      len = int'(sq[27:24]);
      Op = op;
      Funct = fn;
      k = 0;
      do begin
         @(negedge clk);
         z = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
         Zero = z;
         #1;
         st = (k < len) ? sq[4*k +: 4] : 4'd0;
         check($sformatf("op%b_fn%b_step%0d", op, fn, k), model(int'(st), op, fn, z, 1'b0));
         @(posedge clk);
         #1;
         k++;
      end while (State !== 4'd0 && k < 10);
      cycles = k;
   endtask

   typedef struct {
      logic [5:0] op;
      logic [5:0] fn;
      int         zmode;
      int         cpi;
   } vec_t;

   vec_t tbl[14];

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int cyc;
      logic [5:0] op, fn;
      int idx;

      tbl[0]  = '{T_LW,   6'b000000, 0, 5};
      tbl[1]  = '{T_SW,   6'b000000, 1, 4};
      tbl[2]  = '{T_R,    6'b101010, 0, 4};
      tbl[3]  = '{T_R,    6'b100000, 1, 4};
      tbl[4]  = '{T_R,    6'b100010, 0, 4};
      tbl[5]  = '{T_R,    6'b100100, 1, 4};
      tbl[6]  = '{T_R,    6'b100101, 0, 4};
      tbl[7]  = '{T_R,    6'b111000, 0, 4};
      tbl[8]  = '{T_BEQ,  6'b000000, 1, 3};
      tbl[9]  = '{T_BEQ,  6'b000000, 0, 3};
      tbl[10] = '{T_ADDI, 6'b000000, 1, 4};
      tbl[11] = '{T_J,    6'b000000, 0, 3};
      tbl[12] = '{6'b111111, 6'b000000, 0, 2};
      tbl[13] = '{T_BNE,  6'b000000, 0, HAS_BNE ? 3 : 2};

      // Reset held for two edges; outputs must show FETCH with enables low.
      reset = 1'b1; Op = 6'b0; Funct = 6'b0; Zero = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         Zero = 1'b1;
         #1;
         check($sformatf("reset_hold%0d", i), model(0, Op, Funct, 1'b1, 1'b1));
      end
      @(posedge clk);
      #1;
      reset = 1'b0;

      foreach (tbl[i]) begin
         run_instr(tbl[i].op, tbl[i].fn, tbl[i].zmode, cyc);
         check_int($sformatf("cpi_op%b", tbl[i].op), cyc, tbl[i].cpi);
      end

      // sw aborted by reset in MEMADR: no MemWrite, state back to FETCH.
      Op = T_SW; Funct = 6'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         Zero = 1'b0;
         if (k == 2) reset = 1'b1;
         #1;
         check($sformatf("sw_abort_step%0d", k),
               model(k, T_SW, 6'b0, 1'b0, k == 2));
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
      check_int("sw_abort_state", int'(State), 0);
      check_int("sw_abort_memwrite", int'(MemWrite), 0);
      run_instr(T_SW, 6'b0, 2, cyc);
      check_int("sw_after_abort_cpi", cyc, 4);

      // lw aborted by reset in MEMRD: no RegWrite afterwards.
      Op = T_LW;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (k == 3) reset = 1'b1;
         #1;
         check($sformatf("lw_abort_step%0d", k), model(k, T_LW, 6'b0, Zero, k == 3));
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
      check_int("lw_abort_state", int'(State), 0);

      // Randomized instruction stream against the reference sequences.
      for (int n = 0; n < 80; n++) begin
         idx = int'($urandom_range(0, 7));
         case (idx)
            0: op = T_LW;
            1: op = T_SW;
            2: op = T_R;
            3: op = T_BEQ;
            4: op = T_ADDI;
            5: op = T_J;
            6: op = T_BNE;
            default: begin
               do op = 6'($urandom);
               while (op == T_LW || op == T_SW || op == T_R || op == T_BEQ ||
                      op == T_ADDI || op == T_J || op == T_BNE);
            end
         endcase
         if ($urandom_range(0, 1) == 0) begin
            case ($urandom_range(0, 4))
               0: fn = 6'b100000;
               1: fn = 6'b100010;
               2: fn = 6'b100100;
               3: fn = 6'b100101;
               default: fn = 6'b101010;
            endcase
         end else begin
            fn = 6'($urandom);
         end
         run_instr(op, fn, 2, cyc);
         check_int($sformatf("rand%0d_cpi_op%b", n, op), cyc, int'(seq_of(op) >> 24));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
